// File: rtl/wb_pkg.sv
// Shared definitions for the MIPS write-back stage and its register file.
package wb_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG   = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;
endpackage

// File: rtl/regfile_2r1w.sv
// Register array with two write-through read ports, one write port and a raw debug port.
module regfile_2r1w
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic                        we_ok;

  assign we_ok = we && (waddr != ZERO);

  // Entry 0 is reset and never written, so it reads zero once out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we_ok) begin
      for (int i = 1; i < NREG; i++)
        if (waddr == ADDR_W'(i)) regs[i] <= wdata;
    end
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return (a == ZERO) ? '0 : regs[a];
  endfunction

  assign ra_data  = (we_ok && ra_addr == waddr) ? wdata : rd(ra_addr);
  assign rb_data  = (we_ok && rb_addr == waddr) ? wdata : rd(rb_addr);
  assign dbg_data = rd(dbg_addr);
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects load/ALU data, gates the write enable and counts commits.
module wb_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wb_ctrl,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [31:0]       wb_count,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  wb_ctrl_t    ctrl;
  logic [31:0] cnt_q;

  assign ctrl     = wb_ctrl_t'(wb_ctrl);
  assign wb_data  = ctrl.memtoreg ? read_data : alu_result;
  // rst_n in the enable keeps bypass and counting dead while reset is held.
  assign wb_we    = ctrl.regwrite && (write_reg != ADDR_W'(REG_ZERO)) && rst_n;
  assign wb_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (wb_we) cnt_q <= cnt_q + 32'd1;
  end

  regfile_2r1w #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_we),
    .waddr    (write_reg),
    .wdata    (wb_data),
    .ra_addr  (rs_addr),
    .rb_addr  (rt_addr),
    .dbg_addr (dbg_addr),
    .ra_data  (rs_data),
    .rb_data  (rt_data),
    .dbg_data (dbg_data)
  );
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file of the 5-stage MIPS pipeline.
- Sits directly downstream of the MEM/WB pipeline register and consumes its outputs.
- Selects write-back data, commits it to a 32x32 register file and serves the ID-stage read ports.
- Write-through bypass on the read ports, so a same-cycle write is visible to decode without a forwarding stall.

Parameters:
- DATA_W, 32, register/data width in bits
- NREG, 32, number of architectural registers
- ADDR_W, 5, register index width (log2 NREG)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_ctrl  in  2  from MEM/WB: [1]=RegWrite, [0]=MemtoReg
- read_data  in  DATA_W  load data from MEM/WB
- alu_result  in  DATA_W  ALU result from MEM/WB
- write_reg  in  ADDR_W  destination register index from MEM/WB
- rs_addr  in  ADDR_W  ID read port A index
- rt_addr  in  ADDR_W  ID read port B index
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- wb_data  out  DATA_W  selected write-back value, also routed to EX forwarding
- wb_we  out  1  effective write enable
- wb_count  out  32  count of committed register writes
- dbg_addr  in  ADDR_W  debug/testbench read index
- dbg_data  out  DATA_W  debug read data (no bypass)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n low): all registers 1..NREG-1 and wb_count are cleared to 0 immediately, independent of clk.
- While rst_n is low, no write commits, wb_we=0, rs_data/rt_data/dbg_data read 0. wb_data still reflects the mux.
- wb_data is combinational: MemtoReg=1 selects read_data, MemtoReg=0 selects alu_result.
- wb_we is combinational: RegWrite AND (write_reg != 0) AND rst_n.
- Commit: on a rising clk with wb_we=1, reg[write_reg] <= wb_data. Latency is 1 edge to the array.
- Register 0 is hardwired to zero. Writes to it are dropped, produce wb_we=0 and are not counted. It always reads 0 on every port.
- Read ports are combinational with write-through bypass:
  - rs_data = wb_data if wb_we and rs_addr==write_reg; otherwise reg[rs_addr].
  - rt_data follows the same rule with rt_addr.
- Both ports may bypass in the same cycle (rs_addr==rt_addr==write_reg).
- dbg_data = reg[dbg_addr], array contents only, never bypassed.
- wb_count increments by 1 on each rising edge where wb_we=1. It wraps 0xFFFFFFFF -> 0x00000000 with no flag.
- Reset asserted mid-operation: a write pending on the same edge is lost. After rst_n deasserts, the first rising edge with wb_we=1 commits normally.
- No stall or flush input. A bubble arrives as wb_ctrl=00 and writes nothing.

Decomposition:
- Package wb_pkg holds:
  - WB_REGWRITE=1, WB_MEMTOREG=0 (bit indices into wb_ctrl)
  - REG_ZERO=5'd0
  - default DATA_W/NREG/ADDR_W
- One sub-module, regfile_2r1w: the array, reset clear, zero-register rule, two bypassed read ports and one unbypassed debug port.
- The wb_regfile top adds the data mux, wb_we generation and wb_count.

Test Plan:
- Reset: hold rst_n=0 with clk running, wb_ctrl=10, write_reg=3 -> dbg_data reads 0 for all 32 indices, wb_count=0, wb_we=0.
- ALU write: wb_ctrl=10, alu_result=0x0000_1234, write_reg=8, one edge -> dbg_addr=8 gives 0x0000_1234, wb_count=1.
- Load write with bypass: wb_ctrl=11, read_data=0xDEAD_BEEF, write_reg=9, rs_addr=rt_addr=9, before the edge -> rs_data=rt_data=0xDEAD_BEEF while dbg_data(9) still holds its old value; after the edge -> dbg_data(9)=0xDEAD_BEEF.
- Zero register: wb_ctrl=10, write_reg=0, alu_result=0xFFFF_FFFF -> wb_we=0, rs_addr=0 gives 0, wb_count unchanged.
- Bubble: wb_ctrl=00, write_reg=5 -> reg 5 unchanged, no bypass on rs_addr=5, wb_count unchanged.
- Wrap and mid-op reset: force wb_count to 0xFFFF_FFFF, do one write -> count reads 0. Then pulse rst_n low between edges during a write -> registers and count clear asynchronously and the write is lost.
